gray_line_buffer: RTL and testbench

- Sits directly downstream of the RGB-to-gray converter. Consumes its 8-bit gray stream and data-valid strobe.
- Stores the previous WIN_H-1 image rows in line memories.
- For every accepted pixel, emits a vertical column of WIN_H gray pixels to the stereo window/SAD stage, with pixel coordinates.
- Column valid is held off until enough rows are buffered to form a full column.

---
 rtl/gray_line_buffer_if.sv | 26 ++
 rtl/gray_line_buffer.sv | 115 +++++++++++
 tb/tb_gray_line_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_line_buffer_if.sv
// Pixel-stream bundle between the gray converter, the line buffer and the window stage.
// master = upstream driver/observer, slave = gray_line_buffer.
interface gray_line_buffer_if #(
  parameter int unsigned WIN_H = 5,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 9
);
  logic [7:0]         i_gray;
  logic               i_DVAL;
  logic               i_SOF;
  logic [8*WIN_H-1:0] o_col;
  logic               o_col_valid;
  logic [XW-1:0]      o_x;
  logic [YW-1:0]      o_y;
  logic               o_frame_done;

  modport master (
    output i_gray, i_DVAL, i_SOF,
    input  o_col, o_col_valid, o_x, o_y, o_frame_done
  );

  modport slave (
    input  i_gray, i_DVAL, i_SOF,
    output o_col, o_col_valid, o_x, o_y, o_frame_done
  );
endinterface

// File: rtl/gray_line_buffer.sv
// Line buffer emitting a WIN_H-tall gray column per accepted pixel, 1-cycle latency.
// Optional GRAY_LB_EARLY_VALID_EN: emit from row 0 with zero-padded top taps.
module gray_line_buffer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned WIN_H      = 5,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_line_buffer_if.slave  bus
);

  localparam int unsigned NMEM = WIN_H - 1;

  logic [7:0]         mem [NMEM][IMG_WIDTH];
  logic [7:0]         tap [WIN_H];

  logic [XW-1:0]      x_q, x_d, px;
  logic [YW-1:0]      y_q, y_d, py;
  logic [8*WIN_H-1:0] col_q, col_d;
  logic               col_valid_q, col_valid_d;
  logic [XW-1:0]      ox_q, ox_d;
  logic [YW-1:0]      oy_q, oy_d;
  logic               frame_done_q, frame_done_d;
  logic               last_x, last_y;

  // SOF overrides the counters combinationally so a same-cycle pixel lands at (0,0)
  always_comb begin
    px     = bus.i_SOF ? '0 : x_q;
    py     = bus.i_SOF ? '0 : y_q;
    last_x = (px == XW'(IMG_WIDTH - 1));
    last_y = (py == YW'(IMG_HEIGHT - 1));
    tap[0] = bus.i_gray;
    for (int unsigned k = 0; k < NMEM; k++) begin
      tap[k+1] = mem[k][px];
    end
  end

  always_comb begin
    x_d = px;
    y_d = py;
    if (bus.i_DVAL) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : py + 1'b1;
      end else begin
        x_d = px + 1'b1;
      end
    end
  end

  always_comb begin
    col_d        = col_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    col_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (bus.i_DVAL) begin
      ox_d         = px;
      oy_d         = py;
      frame_done_d = last_x && last_y;
      for (int unsigned k = 0; k < WIN_H; k++) begin
        col_d[8*k +: 8] = tap[k];
`ifdef GRAY_LB_EARLY_VALID_EN
        if (int unsigned'(py) < k) begin
          col_d[8*k +: 8] = '0;
        end
`endif
      end
`ifdef GRAY_LB_EARLY_VALID_EN
      col_valid_d = 1'b1;
`else
      col_valid_d = (py >= YW'(WIN_H - 1));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      col_valid_q  <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      col_valid_q  <= col_valid_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Cascade: each memory stores the tap one row above what it feeds next row
  always_ff @(posedge clk) begin
    if (bus.i_DVAL) begin
      for (int unsigned k = 0; k < NMEM; k++) begin
        mem[k][px] <= tap[k];
      end
    end
  end

  assign bus.o_col        = col_q;
  assign bus.o_col_valid  = col_valid_q;
  assign bus.o_x          = ox_q;
  assign bus.o_y          = oy_q;
  assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_line_buffer.sv
// Scoreboard bench for gray_line_buffer on an 8x6 image with a 3-row column.
// Define GRAY_LB_EARLY_VALID_EN on both RTL and bench to exercise the early-valid build.
module tb_gray_line_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned WH = 3;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 3;

  logic clk;
  logic rst_n;

  gray_line_buffer_if #(.WIN_H(WH), .XW(XW), .YW(YW)) bus ();

  gray_line_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .WIN_H     (WH),
    .XW        (XW),
    .YW        (YW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          acc;
    bit          valid;
    logic [23:0] col;
    int          x;
    int          y;
    bit          fd;
    bit          hold_chk;
    bit          f0;
    bit          post_rst;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  img [H][W];
  int          mx, my;
  logic [23:0] last_col;
  int          last_x, last_y;
  bit          last_valid;
  bit          post_rst_pend;
  int          n_chk, n_pass, n_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_front();
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("col_valid", 32'(bus.o_col_valid), 32'(e.valid));
      chk("frame_done", 32'(bus.o_frame_done), 32'(e.fd));
      if (bus.o_frame_done) n_fd++;
      if (e.valid || e.hold_chk) begin
        chk(e.acc ? "col" : "col_hold", 32'(bus.o_col), 32'(e.col));
        chk(e.acc ? "x" : "x_hold", 32'(bus.o_x), 32'(e.x));
        chk(e.acc ? "y" : "y_hold", 32'(bus.o_y), 32'(e.y));
      end
      if (e.post_rst) begin
        chk("post_rst_x", 32'(bus.o_x), 32'd0);
        chk("post_rst_y", 32'(bus.o_y), 32'd0);
      end
`ifdef GRAY_LB_EARLY_VALID_EN
      if (e.f0 && e.acc && e.x == 0 && e.y == 0) begin
        chk("early_00_valid", 32'(bus.o_col_valid), 32'd1);
        chk("early_00_col", 32'(bus.o_col), 32'h000000);
      end
      if (e.f0 && e.acc && e.x == 4 && e.y == 1)
        chk("early_41_col", 32'(bus.o_col), 32'h00040C);
`else
      if (e.f0 && e.acc && e.x == 0 && e.y == 2)
        chk("first_col_02", 32'(bus.o_col), 32'h000810);
      if (e.f0 && e.acc && e.x == 5 && e.y == 5) begin
        chk("col_55", 32'(bus.o_col), 32'h1D252D);
        chk("x_55", 32'(bus.o_x), 32'd5);
        chk("y_55", 32'(bus.o_y), 32'd5);
      end
`endif
    end
  endtask

  // One clock: check the previous cycle's output, then drive and predict this one.
  task automatic cycle(input bit dval, input bit sof, input logic [7:0] g,
                       input bit pat, input bit f0);
    exp_t        e;
    logic [7:0]  gv;
    @(negedge clk);
    check_front();
    if (sof) begin
      mx = 0;
      my = 0;
    end
    gv = pat ? 8'(8 * my + mx) : g;
    bus.i_DVAL = dval;
    bus.i_SOF  = sof;
    bus.i_gray = gv;
    e = '{default: 0};
    e.f0 = f0;
    if (dval) begin
      img[my][mx] = gv;
      e.acc = 1'b1;
      e.x   = mx;
      e.y   = my;
      for (int k = 0; k < int'(WH); k++)
        e.col[8*k +: 8] = (my >= k) ? img[my-k][mx] : 8'h00;
`ifdef GRAY_LB_EARLY_VALID_EN
      e.valid = 1'b1;
`else
      e.valid = (my >= int'(WH) - 1);
`endif
      e.fd = (mx == int'(W) - 1) && (my == int'(H) - 1);
      e.post_rst    = post_rst_pend;
      post_rst_pend = 1'b0;
      last_col   = e.col;
      last_x     = mx;
      last_y     = my;
      last_valid = e.valid;
      if (mx == int'(W) - 1) begin
        mx = 0;
        my = (my == int'(H) - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end else begin
      e.col      = last_col;
      e.x        = last_x;
      e.y        = last_y;
      e.hold_chk = last_valid;
    end
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_front();
    bus.i_DVAL = 1'b0;
    bus.i_SOF  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_col", 32'(bus.o_col), 32'd0);
    chk("rst_valid", 32'(bus.o_col_valid), 32'd0);
    chk("rst_x", 32'(bus.o_x), 32'd0);
    chk("rst_y", 32'(bus.o_y), 32'd0);
    chk("rst_fd", 32'(bus.o_frame_done), 32'd0);
    sbq.delete();
    mx = 0;
    my = 0;
    last_col      = '0;
    last_x        = 0;
    last_y        = 0;
    last_valid    = 1'b0;
    post_rst_pend = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(bus.o_col_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fd = 0;
    rst_n = 1'b0;
    bus.i_DVAL = 1'b0;
    bus.i_SOF  = 1'b0;
    bus.i_gray = '0;
    do_reset();

    // Frame 0: continuous 8*y+x pattern
    for (int i = 0; i < int'(W * H); i++) cycle(1'b1, i == 0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fd_once", 32'(n_fd), 32'd1);

    // Frame 1 aborted by SOF on pixel (3,3)
    for (int i = 0; i < 27; i++) cycle(1'b1, i == 0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("no_fd_aborted", 32'(n_fd), 32'd1);

    // SOF without a pixel, then random duty and data
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 1'b0, 1'b0);

    // Reset in the middle of row 4
    for (int i = 0; i < 36; i++) cycle(1'b1, i == 0, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < int'(3 * W); i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
